// File: rtl/keypad_scanner.sv
// Matrix keypad front end: strobes columns, assembles and debounces whole frames,
// turns clean single-key presses into key codes queued behind a valid/ready FIFO.
module keypad_scanner #(
    parameter int unsigned NUM_COLS   = 3,
    parameter int unsigned NUM_ROWS   = 4,
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned DEBOUNCE   = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned KW        = $clog2(NUM_COLS * NUM_ROWS)
) (
    input  logic                clk,
    input  logic                rst,
    output logic [NUM_COLS-1:0] columnSel,
    input  logic [NUM_ROWS-1:0] scanData,
    output logic [KW-1:0]       key_code,
    output logic                key_valid,
    input  logic                key_ready,
    output logic                any_pressed,
    output logic                overflow,
    input  logic                clr_overflow
);

    localparam int unsigned NK = NUM_COLS * NUM_ROWS;
    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam int unsigned CW = $clog2(NUM_COLS);
    localparam int unsigned SW = $clog2(DEBOUNCE + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    localparam logic [DW-1:0] DivLast   = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] ColLast   = CW'(NUM_COLS - 1);
    localparam logic [SW-1:0] StableMax = SW'(DEBOUNCE);

    // Scan state
    logic [DW-1:0]       div_q, div_d;
    logic [CW-1:0]       col_q, col_d;
    logic [NUM_COLS-1:0] colsel_q, colsel_d;
    logic [NK-1:0]       frame_q, frame_d;
    logic [NK-1:0]       frame_full;
    logic                sample, frame_done;

    // Debounce state
    logic [NK-1:0]       prev_q, prev_d;
    logic [NK-1:0]       deb_q, deb_d;
    logic [SW-1:0]       stable_q, stable_d;
    logic                any_q, any_d;
    logic                same, reached, update, onehot;
    logic                push;
    logic [KW-1:0]       push_code;

    // FIFO state
    logic [KW-1:0]       mem_q [FIFO_DEPTH];
    logic [PW:0]         wptr_q, wptr_d;
    logic [PW:0]         rptr_q, rptr_d;
    logic                ovf_q, ovf_d;
    logic                empty, full, pop, wr_en, drop;

    always_comb begin
        sample     = (div_q == DivLast);
        frame_done = sample && (col_q == ColLast);

        // Current frame with the column being sampled right now merged in
        frame_full = frame_q;
        for (int unsigned c = 0; c < NUM_COLS; c++) begin
            if (col_q == CW'(c)) begin
                frame_full[c*NUM_ROWS +: NUM_ROWS] = scanData;
            end
        end

        div_d    = div_q + 1'b1;
        col_d    = col_q;
        colsel_d = colsel_q;
        frame_d  = frame_q;
        if (sample) begin
            div_d    = '0;
            col_d    = frame_done ? '0 : col_q + 1'b1;
            colsel_d = {colsel_q[NUM_COLS-2:0], colsel_q[NUM_COLS-1]};
            frame_d  = frame_full;
        end
    end

    always_comb begin
        same     = (frame_full == prev_q);
        stable_d = stable_q;
        prev_d   = prev_q;
        if (same) begin
            stable_d = (stable_q == StableMax) ? stable_q : stable_q + 1'b1;
        end else begin
            stable_d = SW'(1);
        end
        // A changed frame starts a fresh run, which matters only when DEBOUNCE == 1
        reached = frame_done && (stable_d == StableMax) && (!same || (stable_q != StableMax));
        update  = reached && (frame_full != deb_q);
        onehot  = (frame_full != '0) && ((frame_full & (frame_full - 1'b1)) == '0);

        push_code = '0;
        for (int unsigned i = 0; i < NK; i++) begin
            if (frame_full[i]) begin
                push_code = KW'(i);
            end
        end

        deb_d = deb_q;
        push  = 1'b0;
        if (frame_done) begin
            prev_d = frame_full;
        end else begin
            stable_d = stable_q;
        end
        if (update) begin
            deb_d = frame_full;
            push  = onehot && (deb_q == '0);
        end
        any_d = |deb_d;
    end

    always_comb begin
        empty = (wptr_q == rptr_q);
        full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
        pop   = !empty && key_ready;
        wr_en = push && (!full || pop);
        drop  = push && full && !pop;

        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_en) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end

        ovf_d = ovf_q;
        if (clr_overflow) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            col_q    <= '0;
            colsel_q <= {{(NUM_COLS-1){1'b0}}, 1'b1};
            frame_q  <= '0;
            prev_q   <= '0;
            deb_q    <= '0;
            stable_q <= '0;
            any_q    <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            div_q    <= div_d;
            col_q    <= col_d;
            colsel_q <= colsel_d;
            frame_q  <= frame_d;
            prev_q   <= prev_d;
            deb_q    <= deb_d;
            stable_q <= stable_d;
            any_q    <= any_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is cleared too so the head reads as zero out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wptr_q[PW-1:0]] <= push_code;
        end
    end

    assign columnSel   = colsel_q;
    assign key_valid   = !empty;
    assign key_code    = mem_q[rptr_q[PW-1:0]];
    assign any_pressed = any_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner: reset, rotation, debounce,
// ghost rejection and FIFO overflow behaviour at a 3x4 geometry.
module tb_keypad_scanner;

    localparam int unsigned NUM_COLS   = 3;
    localparam int unsigned NUM_ROWS   = 4;
    localparam int unsigned SCAN_DIV   = 4;
    localparam int unsigned DEBOUNCE   = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int          FRAME      = NUM_COLS * SCAN_DIV;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NUM_COLS-1:0] column_sel;
    logic [NUM_ROWS-1:0] scan_data = '0;
    logic [3:0]          key_code;
    logic                key_valid;
    logic                key_ready = 1'b0;
    logic                any_pressed;
    logic                overflow;
    logic                clr_overflow = 1'b0;

    int                  n_checks = 0;
    int                  n_fail = 0;
    int                  cyc = 0;
    logic [11:0]         keys = '0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .NUM_COLS  (NUM_COLS),
        .NUM_ROWS  (NUM_ROWS),
        .SCAN_DIV  (SCAN_DIV),
        .DEBOUNCE  (DEBOUNCE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .columnSel   (column_sel),
        .scanData    (scan_data),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .any_pressed (any_pressed),
        .overflow    (overflow),
        .clr_overflow(clr_overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Models the key matrix: rows of the driven column report pressed keys
    task automatic drive_scan();
        scan_data = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (column_sel[c]) scan_data = keys[c*NUM_ROWS +: NUM_ROWS];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        drive_scan();
    endtask

    task automatic frames(input int n);
        repeat (n * FRAME) tick();
    endtask

    task automatic to_boundary();
        while (cyc % FRAME != 0) tick();
    endtask

    task automatic set_keys(input logic [11:0] k);
        keys = k;
        drive_scan();
    endtask

    task automatic pop_expect(input string tag, input logic [3:0] code);
        check({tag, "_valid"}, key_valid, 1);
        check({tag, "_code"}, key_code, code);
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
    endtask

    task automatic press_release(input int k);
        to_boundary();
        set_keys(12'(1) << k);
        frames(4);
        set_keys('0);
        frames(4);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_colsel"}, column_sel, 3'b001);
        check({tag, "_valid"}, key_valid, 0);
        check({tag, "_any"}, any_pressed, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_code"}, key_code, 0);
    endtask

    initial begin
        // Reset, then reset again while column 2 is active
        repeat (3) tick();
        check_reset_state("rst");
        rst = 1'b0;
        cyc = 0;
        repeat (9) tick();
        check("mid_col2", column_sel, 3'b100);
        rst = 1'b1;
        tick();
        check_reset_state("rst_mid");
        rst = 1'b0;
        cyc = 0;

        // Rotation: four cycles per column, 12-cycle frame
        for (int k = 1; k <= 24; k++) begin
            tick();
            check("rot", column_sel, 3'b001 << ((cyc / 4) % 3));
        end
        check("rot_noevent", key_valid, 0);

        // Single press of key 6 (column 1, row 2)
        set_keys(12'h040);
        frames(3);
        check("press_f3_valid", key_valid, 0);
        repeat (FRAME - 1) tick();
        check("press_early_valid", key_valid, 0);
        tick();
        check("press_valid", key_valid, 1);
        check("press_code", key_code, 6);
        check("press_any", any_pressed, 1);
        frames(2);
        check("press_hold_valid", key_valid, 1);
        check("press_hold_code", key_code, 6);
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        check("press_popped", key_valid, 0);
        to_boundary();
        set_keys('0);
        frames(3);
        check("release_f3_any", any_pressed, 1);
        frames(1);
        check("release_any", any_pressed, 0);
        check("release_noevent", key_valid, 0);

        // Bounce: press, open, press, then held
        set_keys(12'h040);
        frames(1);
        set_keys('0);
        frames(1);
        set_keys(12'h040);
        frames(1);
        check("bounce_noevent", key_valid, 0);
        frames(2);
        check("bounce_hold2", key_valid, 0);
        frames(2);
        pop_expect("bounce", 6);
        check("bounce_single", key_valid, 0);
        to_boundary();
        set_keys('0);
        frames(4);

        // Ghost: keys 0 and 5 together, then partial and full release
        set_keys(12'h021);
        frames(6);
        check("ghost_noevent", key_valid, 0);
        check("ghost_any", any_pressed, 1);
        set_keys(12'h001);
        frames(4);
        check("rollover_noevent", key_valid, 0);
        check("rollover_any", any_pressed, 1);
        set_keys('0);
        frames(4);
        check("ghost_rel_any", any_pressed, 0);
        set_keys(12'h020);
        frames(4);
        pop_expect("key5", 5);
        to_boundary();
        set_keys('0);
        frames(4);

        // Overflow: five events into a four-entry queue
        press_release(1);
        press_release(2);
        press_release(3);
        press_release(4);
        check("full_ovf", overflow, 0);
        press_release(7);
        check("ovf_set", overflow, 1);
        check("ovf_head", key_code, 1);
        pop_expect("pop1", 1);
        pop_expect("pop2", 2);
        pop_expect("pop3", 3);
        pop_expect("pop4", 4);
        check("drained", key_valid, 0);
        check("ovf_sticky", overflow, 1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("ovf_clr", overflow, 0);

        // Push and pop on the same edge while full
        press_release(1);
        press_release(2);
        press_release(3);
        press_release(4);
        to_boundary();
        set_keys(12'h080);
        repeat (4 * FRAME - 1) tick();
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        check("pushpop_ovf", overflow, 0);
        set_keys('0);
        frames(4);
        pop_expect("pp2", 2);
        pop_expect("pp3", 3);
        pop_expect("pp4", 4);
        pop_expect("pp7", 7);
        check("pp_drained", key_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Parametrised keypad front end for the door-lock controller. It drives one-hot column selects, samples the row inputs, and debounces whole keypad frames. Each clean single-key press becomes a key code, queued in a small FIFO and presented on a valid/ready interface. It generalises the fixed 3-column/4-row scan with configurable geometry, scan rate and debounce depth, and adds ghost-key rejection, event buffering and overflow reporting.

Parameters:
NUM_COLS, 3, number of keypad columns driven (>=2)
NUM_ROWS, 4, number of row inputs sampled (>=1)
SCAN_DIV, 1000, clock cycles each column is held active (>=2)
DEBOUNCE, 4, consecutive identical frames required before the debounced state updates (>=1)
FIFO_DEPTH, 4, key-event FIFO entries (power of two, >=2)
KW (derived), clog2(NUM_COLS*NUM_ROWS), key code width

Ports:
clk  in  1  single system clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
columnSel  out  NUM_COLS  one-hot active-high column drive
scanData  in  NUM_ROWS  row sense, 1 = key pressed in active column, synchronous to clk
key_code  out  KW  FIFO head: col*NUM_ROWS + row
key_valid  out  1  FIFO non-empty
key_ready  in  1  consumer accepts head when key_valid && key_ready
any_pressed  out  1  debounced frame non-zero
overflow  out  1  sticky: event dropped because FIFO full
clr_overflow  in  1  clears overflow (set wins if same cycle)

Behaviour:
- Reset values: columnSel = 1 (column 0), divider = 0, column index = 0, frame/prev/debounced frames = 0, stable count = 0, FIFO empty, key_valid = 0, key_code = 0, any_pressed = 0, overflow = 0.
- Scan: divider counts 0..SCAN_DIV-1 while a column is active.
  - At divider == SCAN_DIV-1, scanData is written into frame bits [col*NUM_ROWS +: NUM_ROWS].
  - On the same edge, the divider clears and the column advances; NUM_COLS-1 wraps to 0 and columnSel rotates left.
  - Frame period = NUM_COLS*SCAN_DIV cycles.
- Frame completion (sample of column NUM_COLS-1), using the assembled frame F:
  - If F == prev, stable count increments, saturating at DEBOUNCE; otherwise stable count = 1. prev <= F.
  - When stable count reaches DEBOUNCE (transition edge only) and F != debounced, debounced <= F. Evaluate an event against the old debounced value.
  - With DEBOUNCE = 1, every changed frame updates debounced immediately.
- Event rule: push code = index of the single set bit only when new debounced has exactly one bit set and old debounced == 0.
  - Multi-key (ghost) frames: no event.
  - Release to 0: no event; rearms detection.
  - Key-to-key change without passing 0: no event.
- any_pressed = |debounced, registered; updates on the same edge as debounced.
- Latency: the event is written to the FIFO on the frame-completion edge. key_valid is high from the next cycle.
- FIFO behaviour:
  - Pop when key_valid && key_ready.
  - Push when full and no pop: entry dropped, overflow <= 1.
  - Push and pop in the same cycle while full: both happen, no overflow.
  - Push into empty: key_valid rises the next cycle. key_code is the registered head and is stable while valid && !ready.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- rst mid-scan or mid-handshake: all state returns to reset values, queued events are discarded, and the first sample after reset is of column 0 at cycle SCAN_DIV-1.
- scanData bits are ignored except at the sample instant. No metastability synchronizer is included; an upstream 2-flop sync is required.

Test Plan:
(All cases use NUM_COLS=3, NUM_ROWS=4, SCAN_DIV=4, DEBOUNCE=4, FIFO_DEPTH=4.)
1. Reset: assert rst 3 cycles -> columnSel=3'b001, key_valid=0, any_pressed=0, overflow=0, key_code=0. Assert rst again mid-scan at column 2 -> same values the next cycle.
2. Rotation: release rst, scanData=0 -> columnSel 001 for 4 cycles, then 010, 100, 001; 12-cycle frame period; no events.
3. Single press: drive scanData=4'b0100 whenever columnSel=3'b010, held 4 frames, key_ready=0 -> after the 4th frame completes, key_valid=1, key_code=6, any_pressed=1. key_valid stays 1 until key_ready pulses, then 0. Release -> any_pressed=0 after 4 zero frames.
4. Bounce: alternate press/no-press for 3 frames, then hold press for 4 frames -> exactly one event, code 6. No event during bounce.
5. Ghost/rollover: keys 0 and 5 together for 6 frames -> no event, any_pressed=1. Release key 5 only -> still no event (old debounced non-zero). Release all, then press key 5 -> event code 5.
6. Overflow: key_ready=0, press/release keys 1,2,3,4,7 in turn -> 4 entries queued, overflow=1, key_code=1. Pop all 4 -> order 1,2,3,4, then key_valid=0. Pulse clr_overflow -> overflow=0. Push and pop in the same cycle while full -> no overflow.
